// File: rtl/k052109_cpu_timing.sv
// CPU bus timing for the tilemap chip: E/Q clock generation with WAITn stretch,
// read/write strobes, latched interrupt lines and a frame-counted CPU reset.
module k052109_cpu_timing #(
  parameter int QDIV       = 2,
  parameter int NINT       = 3,
  parameter int RST_FRAMES = 8,
  parameter int MAX_STALL  = 15
) (
  input  logic            M24,
  input  logic            RES,
  input  logic            NRD,
  input  logic            CRCS,
  input  logic            WPROT,
  input  logic            WAITn,
  input  logic [NINT-1:0] TRIG,
  input  logic [NINT-1:0] IEN,
  output logic            M12,
  output logic            PE,
  output logic            PQ,
  output logic            RDEN,
  output logic            WREN,
  output logic            WRP,
  output logic            RST,
  output logic [NINT-1:0] INT_N
);

  localparam int PW = $clog2(4*QDIV);
  localparam logic [PW-1:0] PH_LAST = PW'(4*QDIV - 1);
  localparam logic [PW-1:0] Q1      = PW'(QDIV);
  localparam logic [PW-1:0] Q2      = PW'(2*QDIV);
  localparam logic [PW-1:0] Q3      = PW'(3*QDIV);
  localparam logic [7:0]    STALL_MAX  = 8'(MAX_STALL);
  localparam logic [7:0]    FRAMES_MAX = 8'(RST_FRAMES);

  logic            rs_q1, rs_n;
  logic [PW-1:0]   ph, ph_nxt;
  logic [7:0]      stall_cnt, stall_nxt;
  logic            pe_nxt, pq_nxt, wr_win;
  logic            rden_nxt, wren_nxt, wrp_nxt;
  logic [NINT-1:0] trig_s1, trig_s2, trig_d, trig_rise;
  logic [7:0]      frame_cnt;

  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      rs_q1 <= 1'b0;
      rs_n  <= 1'b0;
    end else begin
      rs_q1 <= 1'b1;
      rs_n  <= rs_q1;
    end
  end

  // At the last phase a low WAITn holds E high until released or the stretch limit hits.
  always_comb begin
    ph_nxt    = ph;
    stall_nxt = stall_cnt;
    if (!rs_n) begin
      ph_nxt    = '0;
      stall_nxt = '0;
    end else if (ph == PH_LAST) begin
      if (!WAITn && (stall_cnt != STALL_MAX)) begin
        stall_nxt = stall_cnt + 8'd1;
      end else begin
        ph_nxt    = '0;
        stall_nxt = '0;
      end
    end else begin
      ph_nxt = ph + 1'b1;
    end
    pe_nxt   = (ph_nxt >= Q2);
    pq_nxt   = (ph_nxt >= Q1) && (ph_nxt < Q3);
    wr_win   = (ph_nxt >= Q3);
    rden_nxt = ~(pe_nxt & ~NRD);
    wren_nxt = ~(wr_win & NRD);
    wrp_nxt  = ~(~wren_nxt & ~CRCS & ~WPROT);
  end

  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      ph        <= '0;
      stall_cnt <= '0;
      M12       <= 1'b0;
      PE        <= 1'b0;
      PQ        <= 1'b0;
      RDEN      <= 1'b1;
      WREN      <= 1'b1;
      WRP       <= 1'b1;
    end else begin
      ph        <= ph_nxt;
      stall_cnt <= stall_nxt;
      if (rs_n) M12 <= ~M12;
      PE        <= pe_nxt;
      PQ        <= pq_nxt;
      RDEN      <= rden_nxt;
      WREN      <= wren_nxt;
      WRP       <= wrp_nxt;
    end
  end

  // Edges are masked until the synchronized reset release so early triggers never count.
  assign trig_rise = trig_s2 & ~trig_d & {NINT{rs_n}};

  always_ff @(posedge M24 or negedge RES) begin
    if (!RES) begin
      trig_s1   <= '0;
      trig_s2   <= '0;
      trig_d    <= '0;
      INT_N     <= '1;
      frame_cnt <= '0;
      RST       <= 1'b0;
    end else begin
      trig_s1 <= TRIG;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      INT_N   <= ~IEN | (INT_N & ~trig_rise);
      if (trig_rise[0] && (frame_cnt != FRAMES_MAX)) frame_cnt <= frame_cnt + 8'd1;
      RST     <= (frame_cnt == FRAMES_MAX);
    end
  end

endmodule

// File: tb/tb_k052109_cpu_timing.sv
// Directed bench for k052109_cpu_timing: E/Q trace, WAITn stretch, write strobes,
// interrupt latch/clear, frame-delayed reset and reset during a stall.
module tb_k052109_cpu_timing;

  logic       M24, RES, NRD, CRCS, WPROT, WAITn;
  logic [2:0] TRIG, IEN;
  logic       M12, PE, PQ, RDEN, WREN, WRP, RST;
  logic [2:0] INT_N;
  logic       ns_m12, ns_pe, ns_pq, ns_rden, ns_wren, ns_wrp, ns_rst;
  logic [2:0] ns_int_n;

  int errors = 0;
  int checks = 0;
  int n = 0;

  bit pe_tab  [1:16] = '{0,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1};
  bit pq_tab  [1:16] = '{0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0};
  bit m12_tab [1:16] = '{0,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0};

  k052109_cpu_timing dut (
    .M24(M24), .RES(RES), .NRD(NRD), .CRCS(CRCS), .WPROT(WPROT), .WAITn(WAITn),
    .TRIG(TRIG), .IEN(IEN), .M12(M12), .PE(PE), .PQ(PQ), .RDEN(RDEN),
    .WREN(WREN), .WRP(WRP), .RST(RST), .INT_N(INT_N)
  );

  k052109_cpu_timing #(.MAX_STALL(0)) u_ns (
    .M24(M24), .RES(RES), .NRD(NRD), .CRCS(CRCS), .WPROT(WPROT), .WAITn(WAITn),
    .TRIG(TRIG), .IEN(IEN), .M12(ns_m12), .PE(ns_pe), .PQ(ns_pq), .RDEN(ns_rden),
    .WREN(ns_wren), .WRP(ns_wrp), .RST(ns_rst), .INT_N(ns_int_n)
  );

  initial M24 = 1'b0;
  always #5 M24 = ~M24;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge M24);
    n++;
  endtask

  initial begin
    RES = 1'b0; NRD = 1'b0; CRCS = 1'b1; WPROT = 1'b0; WAITn = 1'b1;
    TRIG = 3'b000; IEN = 3'b000;

    // reset state, with frame pulses that must not count
    tick();
    check("reset_outs", {M12, PE, PQ, RDEN, WREN, WRP, RST}, 7'b0001110);
    check("reset_int", INT_N, 3'b111);
    TRIG[0] = 1'b1; tick(); TRIG[0] = 1'b0; tick();
    TRIG[0] = 1'b1; tick(); TRIG[0] = 1'b0; tick();
    check("reset_hold", {M12, PE, PQ, RST}, 4'b0000);

    RES = 1'b1;
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("pe_trace", PE, pe_tab[i]);
      check("pq_trace", PQ, pq_tab[i]);
      check("m12_trace", M12, m12_tab[i]);
      check("rden_trace", RDEN, !pe_tab[i]);
      check("wren_idle", WREN, 1'b1);
    end
    check("rst_low", RST, 1'b0);

    // short stretch: WAITn low for 5 edges at ph=7
    tick();
    check("pre_stall_pe", PE, 1'b1);
    WAITn = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("stall_peq", {PE, PQ}, 2'b10);
      if (i == 1) check("nostall_inst", ns_pe, 1'b0);
    end
    WAITn = 1'b1;
    tick();
    check("stall_end", PE, 1'b0);

    // held stretch hits the limit
    while (n < 30) tick();
    check("pre_long_pe", PE, 1'b1);
    WAITn = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("long_stall", PE, 1'b1);
    end
    tick();
    check("stall_limit", PE, 1'b0);
    WAITn = 1'b1;

    // write strobes
    NRD = 1'b1; CRCS = 1'b0; WPROT = 1'b0;
    while (n < 54) begin
      tick();
      check("wren_win", WREN, !(n == 52 || n == 53));
      check("wrp_win", WRP, !(n == 52 || n == 53));
      check("rden_wr", RDEN, 1'b1);
    end
    WPROT = 1'b1;
    while (n < 62) begin
      tick();
      check("wren_prot", WREN, !(n == 60 || n == 61));
      check("wrp_prot", WRP, 1'b1);
    end
    NRD = 1'b0; CRCS = 1'b1; WPROT = 1'b0;
    IEN = 3'b010;

    // interrupt latency, hold, clear dominance, no pending memory
    tick(); TRIG[1] = 1'b1;
    tick(); TRIG[1] = 1'b0;
    tick(); check("int_latency_pre", INT_N, 3'b111);
    tick(); check("int_latency", INT_N, 3'b101);
    while (n < 68) tick();
    TRIG[1] = 1'b1; tick(); TRIG[1] = 1'b0;
    tick(); tick(); check("int_repeat", INT_N, 3'b101);
    tick(); TRIG[1] = 1'b1;
    tick(); TRIG[1] = 1'b0;
    tick(); check("int_before_clr", INT_N, 3'b101);
    IEN = 3'b000;
    tick(); check("clear_dominates", INT_N, 3'b111);
    tick(); check("clear_hold", INT_N, 3'b111);
    tick(); check("clear_hold", INT_N, 3'b111);
    IEN = 3'b010;
    tick(); tick(); check("no_pending", INT_N, 3'b111);

    // simultaneous events on all channels (also frame pulse #1)
    IEN = 3'b111;
    tick(); TRIG = 3'b111;
    tick(); TRIG = 3'b000;
    tick(); check("multi_pre", INT_N, 3'b111);
    tick(); check("multi_event", INT_N, 3'b000);
    check("rst_one_frame", RST, 1'b0);

    // frame pulses 2..10; the 8th registers before n=111
    for (int j = 2; j <= 10; j++) begin
      while (n < 80 + 4*(j-1)) begin
        tick();
        check("rst_delay", RST, (n >= 112));
      end
      TRIG[0] = 1'b1;
      tick();
      check("rst_delay", RST, (n >= 112));
      TRIG[0] = 1'b0;
    end
    while (n < 120) begin
      tick();
      check("rst_sat", RST, 1'b1);
    end

    // reset asserted mid-stall with INT_N[0] low
    WAITn = 1'b0;
    while (n < 128) tick();
    check("stall_before_res", {PE, PQ}, 2'b10);
    check("int_before_res", INT_N, 3'b000);
    #2 RES = 1'b0;
    #1 check("async_outs", {M12, PE, PQ, RDEN, WREN, WRP, RST}, 7'b0001110);
    check("async_int", INT_N, 3'b111);
    WAITn = 1'b1;
    tick();
    check("res_held", {PE, RST}, 2'b00);
    RES = 1'b1;
    n = 0;

    for (int j = 1; j <= 9; j++) begin
      while (n < 4 + 4*(j-1)) begin
        tick();
        check("rst_refill", RST, (n >= 36));
      end
      TRIG[0] = 1'b1;
      tick();
      check("rst_refill", RST, (n >= 36));
      TRIG[0] = 1'b0;
    end
    check("int_after_reset", INT_N, 3'b110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
